// File: rtl/axi_lite_selftest_master_if.sv
// rtl/axi_lite_selftest_master_if.sv - AXI4-Lite bus bundle between the self-test master and its slave
interface axi_lite_selftest_master_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_selftest_master.sv
// rtl/axi_lite_selftest_master.sv - AXI4-Lite write/readback register self-test master
// Optional handshake watchdog enabled by defining TIMEOUT_EN.
module axi_lite_selftest_master #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_REGS  = 4,
    parameter int unsigned       TIMEOUT   = 255
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_index,
    output logic        err_resp,
    output logic        err_timeout,
    axi_lite_selftest_master_if.master m_axi
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WB, S_RA, S_RD, S_CHK, S_DONE
    } state_t;

    localparam logic [3:0] K_LAST = 4'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [3:0]        k_q;
    logic              aw_done_q, w_done_q;
    logic              pass_q, err_resp_q, err_timeout_q;
    logic [3:0]        err_index_q;
    logic              aw_vld, w_vld, b_rdy, ar_vld, r_rdy;
    logic              aw_fire, w_fire, waiting, wd_expired;
    logic              accept, advance, finish_ok, fail_resp, fail_data, fail_to;

    assign aw_fire = aw_vld && m_axi.M_AXI_AWREADY;
    assign w_fire  = w_vld && m_axi.M_AXI_WREADY;
    assign waiting = (state_q == S_WR) || (state_q == S_WB) ||
                     (state_q == S_RA) || (state_q == S_RD);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        advance   = 1'b0;
        finish_ok = 1'b0;
        fail_resp = 1'b0;
        fail_data = 1'b0;
        fail_to   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // Address and data may complete in either order; both must be in before moving on.
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = S_WB;
                else if (wd_expired) begin fail_to = 1'b1; state_d = S_DONE; end
            end
            S_WB: begin
                if (m_axi.M_AXI_BVALID) begin
                    if (m_axi.M_AXI_BRESP != 2'b00) begin fail_resp = 1'b1; state_d = S_DONE; end
                    else state_d = S_RA;
                end else if (wd_expired) begin fail_to = 1'b1; state_d = S_DONE; end
            end
            S_RA: begin
                if (m_axi.M_AXI_ARREADY) state_d = S_RD;
                else if (wd_expired) begin fail_to = 1'b1; state_d = S_DONE; end
            end
            S_RD: begin
                if (m_axi.M_AXI_RVALID) begin
                    if (m_axi.M_AXI_RRESP != 2'b00) begin fail_resp = 1'b1; state_d = S_DONE; end
                    else state_d = S_CHK;
                end else if (wd_expired) begin fail_to = 1'b1; state_d = S_DONE; end
            end
            S_CHK: begin
                if (rdata_q != wdata_q) begin fail_data = 1'b1; state_d = S_DONE; end
                else if (k_q == K_LAST) begin finish_ok = 1'b1; state_d = S_DONE; end
                else begin advance = 1'b1; state_d = S_WR; end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != S_IDLE) && (state_q != S_DONE);
        done   = (state_q == S_DONE);
        aw_vld = (state_q == S_WR) && !aw_done_q;
        w_vld  = (state_q == S_WR) && !w_done_q;
        b_rdy  = (state_q == S_WB);
        ar_vld = (state_q == S_RA);
        r_rdy  = (state_q == S_RD);
    end

    // Per-register address/pattern are kept in registers so the bus stays stable while waiting.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            k_q           <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            pass_q        <= 1'b0;
            err_index_q   <= '0;
            err_resp_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire)  w_done_q  <= 1'b1;
            if (accept) begin
                addr_q        <= BASE_ADDR;
                wdata_q       <= seed;
                k_q           <= '0;
                aw_done_q     <= 1'b0;
                w_done_q      <= 1'b0;
                pass_q        <= 1'b0;
                err_index_q   <= '0;
                err_resp_q    <= 1'b0;
                err_timeout_q <= 1'b0;
            end
            if (advance) begin
                addr_q    <= addr_q + ADDR_W'(4);
                wdata_q   <= wdata_q + 32'h1111_1111;
                k_q       <= k_q + 4'd1;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (r_rdy && m_axi.M_AXI_RVALID) rdata_q <= m_axi.M_AXI_RDATA;
            if (finish_ok) pass_q <= 1'b1;
            if (fail_resp || fail_data || fail_to) err_index_q <= k_q;
            if (fail_resp) err_resp_q <= 1'b1;
            if (fail_to)   err_timeout_q <= 1'b1;
        end
    end

`ifdef TIMEOUT_EN
    logic [15:0] wd_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                 wd_q <= '0;
        else if (state_d != state_q) wd_q <= '0;
        else if (waiting)           wd_q <= wd_q + 16'd1;
    end

    assign wd_expired = waiting && (wd_q == 16'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = waiting && (TIMEOUT == 0);
    assign wd_expired     = 1'b0;
`endif

    assign pass        = pass_q;
    assign err_index   = err_index_q;
    assign err_resp    = err_resp_q;
    assign err_timeout = err_timeout_q;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = aw_vld;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = w_vld;
    assign m_axi.M_AXI_BREADY  = b_rdy;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = ar_vld;
    assign m_axi.M_AXI_RREADY  = r_rdy;
endmodule
